apple_placer: RTL and testbench



---
 rtl/snake_pkg.sv | 21 ++
 rtl/apple_placer_lfsr16.sv | 27 ++
 rtl/apple_placer.sv | 166 ++++++++++++++++
 tb/tb_apple_placer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game datapath.
//   GRID_SIZE      : board edge length (cells)
//   APPLE_START_X/Y: apple position after reset
//   coord_t        : 4-bit grid coordinate
//   placer_state_t : apple placer FSM states
package snake_pkg;

  localparam int unsigned GRID_SIZE     = 16;
  localparam int unsigned APPLE_START_X = 12;
  localparam int unsigned APPLE_START_Y = 12;

  typedef logic [3:0] coord_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PICK = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } placer_state_t;

endpackage

// File: rtl/apple_placer_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting left.
//   clk   : clock
//   reset : synchronous active-low reset, loads seed
//   seed  : reset value (must be non-zero)
//   q     : current LFSR state
module lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk) begin
    if (!reset) lfsr_q <= seed;
    else        lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/apple_placer.sv
// Picks a free cell for the next apple: up to MAX_TRIES random candidates,
// then a linear scan from just past the last candidate. Result is published
// as a registered coordinate and a registered one-hot 16x16 map.
//   clk         : system clock
//   reset       : synchronous active-low reset
//   occupied    : [x][y] snake occupancy, sampled live
//   place_req   : single-cycle placement request (accepted in IDLE only)
//   apple_x/y   : committed apple row/column
//   apple_valid : an apple is on the board
//   apple_map   : one-hot of the apple cell, zero when not valid
//   busy        : placement in progress (PICK/SCAN/DONE)
//   place_done  : one-cycle pulse at end of a placement attempt
//   board_full  : sticky, no free cell found on the last attempt
module apple_placer
  import snake_pkg::*;
#(
  parameter int unsigned GRID      = GRID_SIZE,
  parameter int unsigned MAX_TRIES = 8,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned START_X   = APPLE_START_X,
  parameter int unsigned START_Y   = APPLE_START_Y
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0][15:0] occupied,
  input  logic              place_req,
  output logic [3:0]        apple_x,
  output logic [3:0]        apple_y,
  output logic              apple_valid,
  output logic [15:0][15:0] apple_map,
  output logic              busy,
  output logic              place_done,
  output logic              board_full
);

  localparam int unsigned CELLS = GRID * GRID;

  placer_state_t    state_q, state_d;
  logic [3:0]       tries_q, tries_d;
  logic [7:0]       scan_idx_q, scan_idx_d;
  logic [7:0]       scan_cnt_q, scan_cnt_d;
  coord_t           ax_q, ax_d;
  coord_t           ay_q, ay_d;
  logic             valid_q, valid_d;
  logic [15:0][15:0] map_q, map_d;
  logic             full_q, full_d;

  logic [15:0]      lfsr_q;
  logic             lfsr_unused;
  coord_t           cand_x, cand_y, scan_x, scan_y;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (SEED),
    .q     (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[15:8];
  assign cand_x      = lfsr_q[7:4];
  assign cand_y      = lfsr_q[3:0];
  assign scan_x      = scan_idx_q[7:4];
  assign scan_y      = scan_idx_q[3:0];

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      tries_q    <= '0;
      scan_idx_q <= '0;
      scan_cnt_q <= '0;
      ax_q       <= coord_t'(START_X);
      ay_q       <= coord_t'(START_Y);
      valid_q    <= 1'b1;
      map_q      <= '0;
      map_q[START_X[3:0]][START_Y[3:0]] <= 1'b1;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tries_q    <= tries_d;
      scan_idx_q <= scan_idx_d;
      scan_cnt_q <= scan_cnt_d;
      ax_q       <= ax_d;
      ay_q       <= ay_d;
      valid_q    <= valid_d;
      map_q      <= map_d;
      full_q     <= full_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    tries_d    = tries_q;
    scan_idx_d = scan_idx_q;
    scan_cnt_d = scan_cnt_q;
    ax_d       = ax_q;
    ay_d       = ay_q;
    valid_d    = valid_q;
    map_d      = map_q;
    full_d     = full_q;

    unique case (state_q)
      IDLE: begin
        if (place_req) begin
          state_d = PICK;
          valid_d = 1'b0;
          map_d   = '0;
          tries_d = '0;
        end
      end
      PICK: begin
        if (!occupied[cand_x][cand_y]) begin
          ax_d    = cand_x;
          ay_d    = cand_y;
          valid_d = 1'b1;
          full_d  = 1'b0;
          map_d   = '0;
          map_d[cand_x][cand_y] = 1'b1;
          state_d = DONE;
        end else begin
          tries_d = tries_q + 4'd1;
          // The miss that brings the count to MAX_TRIES also seeds the scan.
          if (tries_q == 4'(MAX_TRIES - 1)) begin
            scan_idx_d = {cand_x, cand_y} + 8'd1;
            scan_cnt_d = '0;
            state_d    = SCAN;
          end
        end
      end
      SCAN: begin
        if (!occupied[scan_x][scan_y]) begin
          ax_d    = scan_x;
          ay_d    = scan_y;
          valid_d = 1'b1;
          full_d  = 1'b0;
          map_d   = '0;
          map_d[scan_x][scan_y] = 1'b1;
          state_d = DONE;
        end else begin
          scan_idx_d = scan_idx_q + 8'd1;
          scan_cnt_d = scan_cnt_q + 8'd1;
          if (scan_cnt_q == 8'(CELLS - 1)) begin
            full_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy       = (state_q != IDLE);
    place_done = (state_q == DONE);
  end

  assign apple_x     = ax_q;
  assign apple_y     = ay_q;
  assign apple_valid = valid_q;
  assign apple_map   = map_q;
  assign board_full  = full_q;

endmodule

// File: tb/tb_apple_placer.sv
module tb_apple_placer;

  logic              clk = 1'b0;
  logic              reset;
  logic [15:0][15:0] occ;
  logic              place_req;
  logic [3:0]        apple_x, apple_y;
  logic              apple_valid;
  logic [15:0][15:0] apple_map;
  logic              busy, place_done, board_full;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  apple_placer #(
    .GRID      (16),
    .MAX_TRIES (8),
    .SEED      (16'hACE1),
    .START_X   (12),
    .START_Y   (12)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .occupied    (occ),
    .place_req   (place_req),
    .apple_x     (apple_x),
    .apple_y     (apple_y),
    .apple_valid (apple_valid),
    .apple_map   (apple_map),
    .busy        (busy),
    .place_done  (place_done),
    .board_full  (board_full)
  );

  // Reference LFSR: x^16+x^14+x^13+x^11+1, left shift, reloaded while in reset
  always @(posedge clk) begin
    if (!reset) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] onehot(input logic [3:0] x, input logic [3:0] y);
    logic [15:0][15:0] m;
    m = '0;
    m[x][y] = 1'b1;
    return m;
  endfunction

  // Pulse place_req for one edge, then count negedges until place_done.
  // first_lfsr is the LFSR value during the first PICK cycle.
  task automatic request(input int budget, output int cyc, output logic [15:0] first_lfsr);
    @(negedge clk) place_req = 1'b1;
    @(posedge clk);
    @(negedge clk) place_req = 1'b0;
    first_lfsr = m_lfsr;
    cyc = 1;
    while (!place_done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_x"},     apple_x,     4'd12);
    check({tag, "_y"},     apple_y,     4'd12);
    check({tag, "_valid"}, apple_valid, 1'b1);
    check({tag, "_map"},   apple_map,   onehot(4'd12, 4'd12));
    check({tag, "_busy"},  busy,        1'b0);
    check({tag, "_done"},  place_done,  1'b0);
    check({tag, "_full"},  board_full,  1'b0);
  endtask

  initial begin
    int          cyc;
    int          dones;
    logic [15:0] fl;

    reset = 1'b0; occ = '0; place_req = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;

    // Idle with no request: reset values persist
    repeat (6) @(negedge clk);
    check_reset_vals("idle");

    // Empty board: immediate hit on first candidate
    request(20, cyc, fl);
    check("hit_latency", 32'(cyc),    32'd2);
    check("hit_x",       apple_x,     fl[7:4]);
    check("hit_y",       apple_y,     fl[3:0]);
    check("hit_valid",   apple_valid, 1'b1);
    check("hit_map",     apple_map,   onehot(fl[7:4], fl[3:0]));
    // Request raised during DONE is dropped
    place_req = 1'b1;
    @(negedge clk) place_req = 1'b0;
    check("drop_done",   place_done,  1'b0);
    check("drop_busy",   busy,        1'b0);
    repeat (3) @(negedge clk);
    check("drop_idle",   busy,        1'b0);

    // Single free cell (5,9)
    occ = '1; occ[5][9] = 1'b0;
    request(300, cyc, fl);
    check("one_in_bound", 32'(cyc <= 265), 32'd1);
    check("one_x",     apple_x,     4'd5);
    check("one_y",     apple_y,     4'd9);
    check("one_valid", apple_valid, 1'b1);
    check("one_full",  board_full,  1'b0);
    check("one_map",   apple_map,   onehot(4'd5, 4'd9));

    // Single free cell at (0,0): scan crosses the 255->0 wrap unless hit at once
    occ = '1; occ[0][0] = 1'b0;
    request(300, cyc, fl);
    check("wrap_x",     apple_x,     4'd0);
    check("wrap_y",     apple_y,     4'd0);
    check("wrap_valid", apple_valid, 1'b1);

    // Full board: exact worst-case latency
    occ = '1;
    request(400, cyc, fl);
    check("full_latency", 32'(cyc),    32'd265);
    check("full_flag",    board_full,  1'b1);
    check("full_valid",   apple_valid, 1'b0);
    check("full_map",     apple_map,   256'd0);
    @(negedge clk);
    check("full_sticky",  board_full,  1'b1);
    check("full_idle",    busy,        1'b0);

    // Successful placement clears board_full
    occ = '1; occ[3][14] = 1'b0;
    request(300, cyc, fl);
    check("clr_full",  board_full, 1'b0);
    check("clr_x",     apple_x,    4'd3);
    check("clr_y",     apple_y,    4'd14);

    // Extra requests while busy: one done, commit unaffected
    occ = '1; occ[5][9] = 1'b0;
    dones = 0;
    @(negedge clk) place_req = 1'b1;
    @(negedge clk) place_req = 1'b0;
    for (int unsigned i = 0; i < 300; i++) begin
      if (i == 2 || i == 5 || i == 11) place_req = 1'b1;
      else                             place_req = 1'b0;
      @(negedge clk);
      if (place_done) dones++;
    end
    place_req = 1'b0;
    check("busy_req_dones", 32'(dones), 32'd1);
    check("busy_req_x",     apple_x,    4'd5);
    check("busy_req_y",     apple_y,    4'd9);
    check("busy_req_busy",  busy,       1'b0);

    // Reset in the middle of SCAN
    occ = '1;
    @(negedge clk) place_req = 1'b1;
    @(negedge clk) place_req = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_busy", busy, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("mid_rst");
    reset = 1'b1;
    dones = 0;
    for (int unsigned i = 0; i < 300; i++) begin
      @(negedge clk);
      if (place_done) dones++;
    end
    check("mid_no_done", 32'(dones), 32'd0);
    check("mid_after_x", apple_x,    4'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
